// File: rtl/uart_mem_bridge_if.sv
// rtl/uart_mem_bridge_if.sv - host-side byte streams and status of uart_mem_bridge
//   rx_wr_en/rx_din/rx_full    : host push into the RX FIFO
//   tx_rd_en/tx_dout/tx_empty  : host pop from the TX FIFO (tx_dout registered)
//   state_leds                 : one-hot controller state, zero in IDLE
interface uart_mem_bridge_if #(
  parameter int FIFO_WIDTH = 8
);
  logic                  rx_wr_en;
  logic [FIFO_WIDTH-1:0] rx_din;
  logic                  rx_full;
  logic                  tx_rd_en;
  logic [FIFO_WIDTH-1:0] tx_dout;
  logic                  tx_empty;
  logic [5:0]            state_leds;

  modport master (
    output rx_wr_en, rx_din, tx_rd_en,
    input  rx_full, tx_dout, tx_empty, state_leds
  );

  modport slave (
    input  rx_wr_en, rx_din, tx_rd_en,
    output rx_full, tx_dout, tx_empty, state_leds
  );
endinterface

// File: rtl/uart_mem_bridge.sv
// rtl/uart_mem_bridge.sv - byte-command bridge: RX FIFO -> packet controller -> 256x8 RAM -> TX FIFO
//   uart_mem_bridge_fifo : clk, rst (sync active-low), wr_en/din/full, rd_en/dout/empty
//   uart_mem_bridge      : clk, rst (sync active-low), bus (uart_mem_bridge_if.slave)
module uart_mem_bridge_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] buf_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             push, pop;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign dout  = dout_q;

  always_comb begin
    push     = wr_en && !full;
    pop      = rd_en && !empty;
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    dout_d   = pop ? buf_q[rd_ptr_q] : dout_q;
    count_d  = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push) buf_q[wr_ptr_q] <= din;
  end
endmodule

module uart_mem_bridge #(
  parameter int FIFO_WIDTH = 8,
  parameter int FIFO_DEPTH = 8,
  parameter int MEM_DEPTH  = 256
) (
  input logic               clk,
  input logic               rst,
  uart_mem_bridge_if.slave  bus
);
  localparam logic [FIFO_WIDTH-1:0] CMD_WRITE = FIFO_WIDTH'(49);
  localparam logic [FIFO_WIDTH-1:0] CMD_READ  = FIFO_WIDTH'(48);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_CMD, S_READ_ADDR, S_READ_DATA, S_WRITE_MEM_VAL, S_READ_MEM_VAL, S_ECHO_VAL
  } state_t;

  state_t                state_q, state_d;
  logic                  pend_q, pend_d;
  logic [FIFO_WIDTH-1:0] cmd_q, cmd_d, addr_q, addr_d, data_q, data_d, rdata_q, rdata_d;
  logic                  rx_rd_en, rx_empty, tx_wr_en, tx_full, mem_we;
  logic [FIFO_WIDTH-1:0] rx_dout, tx_din;
  logic [FIFO_WIDTH-1:0] mem [0:MEM_DEPTH-1];

  uart_mem_bridge_fifo #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_rx (
    .clk(clk), .rst(rst),
    .wr_en(bus.rx_wr_en), .din(bus.rx_din), .full(bus.rx_full),
    .rd_en(rx_rd_en), .dout(rx_dout), .empty(rx_empty)
  );

  uart_mem_bridge_fifo #(.WIDTH(FIFO_WIDTH), .DEPTH(FIFO_DEPTH)) u_tx (
    .clk(clk), .rst(rst),
    .wr_en(tx_wr_en), .din(tx_din), .full(tx_full),
    .rd_en(bus.tx_rd_en), .dout(bus.tx_dout), .empty(bus.tx_empty)
  );

  // Each byte-fetch state runs in two phases: pend_q=0 issues a single-cycle
  // pop once RX has data, pend_q=1 consumes the registered FIFO output.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    cmd_d    = cmd_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rdata_d  = rdata_q;
    rx_rd_en = 1'b0;
    tx_wr_en = 1'b0;
    tx_din   = rdata_q;
    mem_we   = 1'b0;
    case (state_q)
      S_IDLE: if (!rx_empty) state_d = S_READ_CMD;
      S_READ_CMD: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          cmd_d   = rx_dout;
          state_d = (rx_dout == CMD_WRITE || rx_dout == CMD_READ) ? S_READ_ADDR : S_IDLE;
        end else if (!rx_empty) begin
          rx_rd_en = 1'b1;
          pend_d   = 1'b1;
        end
      end
      S_READ_ADDR: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          addr_d  = rx_dout;
          state_d = (cmd_q == CMD_WRITE) ? S_READ_DATA : S_READ_MEM_VAL;
        end else if (!rx_empty) begin
          rx_rd_en = 1'b1;
          pend_d   = 1'b1;
        end
      end
      S_READ_DATA: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          data_d  = rx_dout;
          state_d = S_WRITE_MEM_VAL;
        end else if (!rx_empty) begin
          rx_rd_en = 1'b1;
          pend_d   = 1'b1;
        end
      end
      S_WRITE_MEM_VAL: begin
        mem_we  = 1'b1;
        state_d = S_IDLE;
      end
      S_READ_MEM_VAL: begin
        rdata_d = mem[addr_q];
        state_d = S_ECHO_VAL;
      end
      S_ECHO_VAL: begin
        if (!tx_full) begin
          tx_wr_en = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.state_leds = 6'b000000;
    case (state_q)
      S_READ_CMD:      bus.state_leds = 6'b000001;
      S_READ_ADDR:     bus.state_leds = 6'b000010;
      S_READ_DATA:     bus.state_leds = 6'b000100;
      S_WRITE_MEM_VAL: bus.state_leds = 6'b001000;
      S_READ_MEM_VAL:  bus.state_leds = 6'b010000;
      S_ECHO_VAL:      bus.state_leds = 6'b100000;
      default:         bus.state_leds = 6'b000000;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pend_q  <= 1'b0;
      cmd_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
    end
  end

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[addr_q] <= data_q;
  end
endmodule

// File: tb/tb_uart_mem_bridge.sv
// tb/tb_uart_mem_bridge.sv - scoreboard bench for uart_mem_bridge
module tb_uart_mem_bridge;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_mem_bridge_if bus ();
  uart_mem_bridge dut (.clk(clk), .rst(rst), .bus(bus));

  logic       f_wr, f_rd, f_full, f_empty;
  logic [7:0] f_din, f_dout;
  uart_mem_bridge_fifo #(.WIDTH(8), .DEPTH(8)) u_fchk (
    .clk(clk), .rst(rst), .wr_en(f_wr), .din(f_din), .full(f_full),
    .rd_en(f_rd), .dout(f_dout), .empty(f_empty)
  );

  int         checks = 0;
  int         failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model [256];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] b);
    int n = 0;
    while (bus.rx_full && n < 500) begin
      tick();
      n++;
    end
    if (bus.rx_full) begin
      checks++;
      failures++;
      $display("FAIL rx_push_timeout: rx_full=%0b required 0", bus.rx_full);
    end
    bus.rx_din   = b;
    bus.rx_wr_en = 1'b1;
    tick();
    bus.rx_wr_en = 1'b0;
  endtask

  task automatic send_write(input logic [7:0] a, input logic [7:0] d);
    push_byte(8'd49);
    push_byte(a);
    push_byte(d);
    model[a] = d;
  endtask

  task automatic send_read(input logic [7:0] a);
    push_byte(8'd48);
    push_byte(a);
    exp_q.push_back(model[a]);
  endtask

  task automatic pop_check(input string name);
    int n = 0;
    logic [7:0] exp;
    while (bus.tx_empty && n < 500) begin
      tick();
      n++;
    end
    checks++;
    if (bus.tx_empty) begin
      failures++;
      $display("FAIL %s_timeout: tx_empty=%0b required 0", name, bus.tx_empty);
    end else begin
      bus.tx_rd_en = 1'b1;
      tick();
      bus.tx_rd_en = 1'b0;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL %s_extra: got %0d with no expected byte", name, bus.tx_dout);
      end else begin
        exp = exp_q.pop_front();
        if (bus.tx_dout !== exp) begin
          failures++;
          $display("FAIL %s: tx_dout=%0d required %0d", name, bus.tx_dout, exp);
        end
      end
    end
  endtask

  task automatic check_mem(input logic [7:0] a, input logic [7:0] d, input string name);
    checks++;
    if (dut.mem[a] !== d) begin
      failures++;
      $display("FAIL %s: RAM[%0d]=%0d required %0d", name, a, dut.mem[a], d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) tick();
    checks += 4;
    if (bus.rx_full !== 1'b0) begin failures++; $display("FAIL reset_rx_full: %b required 0", bus.rx_full); end
    if (bus.tx_empty !== 1'b1) begin failures++; $display("FAIL reset_tx_empty: %b required 1", bus.tx_empty); end
    if (bus.tx_dout !== 8'd0) begin failures++; $display("FAIL reset_tx_dout: %0d required 0", bus.tx_dout); end
    if (bus.state_leds !== 6'b0) begin failures++; $display("FAIL reset_leds: %b required 000000", bus.state_leds); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_write_read();
    send_write(8'd10, 8'd65);
    repeat (10) tick();
    check_mem(8'd10, 8'd65, "write_read_ram");
    send_read(8'd10);
    pop_check("write_read_tx");
  endtask

  task automatic test_back_to_back_writes();
    for (int i = 0; i < 8; i++) begin
      send_write(8'(10 + i), 8'(65 + i));
      repeat (10) tick();
      check_mem(8'(10 + i), 8'(65 + i), "b2b_write_ram");
    end
  endtask

  task automatic test_back_to_back_reads();
    for (int i = 0; i < 8; i++) send_read(8'(10 + i));
    for (int i = 0; i < 8; i++) pop_check("b2b_read");
  endtask

  task automatic test_gaps();
    push_byte(8'd49);
    repeat (5) tick();
    checks++;
    if (bus.state_leds !== 6'b000010) begin
      failures++;
      $display("FAIL gap_wait_addr: leds=%b required 000010", bus.state_leds);
    end
    push_byte(8'd18);
    repeat (5) tick();
    push_byte(8'd73);
    model[18] = 8'd73;
    repeat (10) tick();
    check_mem(8'd18, 8'd73, "gap_ram");
  endtask

  task automatic test_tx_backpressure();
    send_write(8'd19, 8'd74);
    repeat (10) tick();
    for (int a = 10; a <= 19; a++) send_read(8'(a));
    repeat (40) tick();
    checks += 3;
    if (bus.tx_empty !== 1'b0) begin failures++; $display("FAIL bp_tx_empty: %b required 0", bus.tx_empty); end
    if (dut.u_tx.count_q !== 4'd8) begin failures++; $display("FAIL bp_tx_count: %0d required 8", dut.u_tx.count_q); end
    if (bus.state_leds !== 6'b100000) begin failures++; $display("FAIL bp_stall: leds=%b required 100000", bus.state_leds); end
    for (int i = 0; i < 10; i++) pop_check("bp_drain");
  endtask

  task automatic test_fifo_boundaries();
    // Stall the controller in ECHO_VAL so RX stops draining.
    for (int k = 0; k < 9; k++) send_read(8'd10);
    repeat (60) tick();
    checks += 2;
    if (bus.state_leds !== 6'b100000) begin failures++; $display("FAIL fb_stall: leds=%b required 100000", bus.state_leds); end
    if (dut.u_rx.count_q !== 4'd0) begin failures++; $display("FAIL fb_rx_drained: count=%0d required 0", dut.u_rx.count_q); end
    for (int k = 0; k < 4; k++) send_read(8'(11 + k));
    checks++;
    if (bus.rx_full !== 1'b1) begin failures++; $display("FAIL fb_rx_full: %b required 1", bus.rx_full); end
    bus.rx_din   = 8'd48;
    bus.rx_wr_en = 1'b1;
    tick();
    bus.rx_wr_en = 1'b0;
    checks++;
    if (dut.u_rx.count_q !== 4'd8) begin failures++; $display("FAIL fb_ninth_ignored: count=%0d required 8", dut.u_rx.count_q); end
    while (exp_q.size() != 0) pop_check("fb_drain");
    repeat (20) tick();
    checks += 2;
    if (bus.tx_empty !== 1'b1) begin failures++; $display("FAIL fb_tx_empty_end: %b required 1", bus.tx_empty); end
    if (bus.state_leds !== 6'b0) begin failures++; $display("FAIL fb_idle_end: leds=%b required 000000", bus.state_leds); end

    // Standalone FIFO: simultaneous push/pop at count 0, 8 and 7.
    f_wr = 1'b1; f_rd = 1'b1; f_din = 8'hA5;
    tick();
    f_wr = 1'b0; f_rd = 1'b0;
    checks += 2;
    if (u_fchk.count_q !== 4'd1) begin failures++; $display("FAIL fifo_pp_empty_count: %0d required 1", u_fchk.count_q); end
    if (f_dout !== 8'h00) begin failures++; $display("FAIL fifo_pp_empty_dout: %0h required 0", f_dout); end
    for (int k = 1; k < 8; k++) begin
      f_wr = 1'b1; f_din = 8'(k);
      tick();
    end
    f_wr = 1'b0;
    checks++;
    if (f_full !== 1'b1) begin failures++; $display("FAIL fifo_full: %b required 1", f_full); end
    f_wr = 1'b1; f_rd = 1'b1; f_din = 8'hEE;
    tick();
    checks += 2;
    if (u_fchk.count_q !== 4'd7) begin failures++; $display("FAIL fifo_pp_full_count: %0d required 7", u_fchk.count_q); end
    if (f_dout !== 8'hA5) begin failures++; $display("FAIL fifo_pp_full_dout: %0h required a5", f_dout); end
    f_din = 8'h08;
    tick();
    f_wr = 1'b0; f_rd = 1'b0;
    checks += 2;
    if (u_fchk.count_q !== 4'd7) begin failures++; $display("FAIL fifo_pp_mid_count: %0d required 7", u_fchk.count_q); end
    if (f_dout !== 8'h01) begin failures++; $display("FAIL fifo_pp_mid_dout: %0h required 01", f_dout); end
    for (int k = 2; k <= 8; k++) begin
      f_rd = 1'b1;
      tick();
      checks++;
      if (f_dout !== 8'(k)) begin failures++; $display("FAIL fifo_order: %0h required %0h", f_dout, 8'(k)); end
    end
    f_rd = 1'b0;
    checks++;
    if (f_empty !== 1'b1) begin failures++; $display("FAIL fifo_empty_end: %b required 1", f_empty); end
  endtask

  task automatic test_reset_mid_packet();
    push_byte(8'd49);
    push_byte(8'd20);
    tick();
    rst = 1'b0;
    repeat (2) tick();
    checks += 4;
    if (bus.state_leds !== 6'b0) begin failures++; $display("FAIL mid_rst_leds: %b required 000000", bus.state_leds); end
    if (bus.rx_full !== 1'b0) begin failures++; $display("FAIL mid_rst_rx_full: %b required 0", bus.rx_full); end
    if (bus.tx_empty !== 1'b1) begin failures++; $display("FAIL mid_rst_tx_empty: %b required 1", bus.tx_empty); end
    if (dut.u_rx.count_q !== 4'd0) begin failures++; $display("FAIL mid_rst_rx_count: %0d required 0", dut.u_rx.count_q); end
    rst = 1'b1;
    tick();
    send_write(8'd20, 8'd99);
    repeat (10) tick();
    check_mem(8'd20, 8'd99, "post_rst_ram");
    send_read(8'd20);
    pop_check("post_rst_read");
  endtask

  initial begin
    bus.rx_wr_en = 1'b0;
    bus.rx_din   = 8'd0;
    bus.tx_rd_en = 1'b0;
    f_wr = 1'b0; f_rd = 1'b0; f_din = 8'd0;
    rst  = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back_writes();
    test_back_to_back_reads();
    test_gaps();
    test_tx_backpressure();
    test_fifo_boundaries();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
